// File: rtl/axi_slave_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_slave_ram_pkg
// Description : Shared AXI response/burst codes and FSM state encodings for
//               the AXI4 slave RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_slave_ram_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    typedef logic [1:0] wr_state_t;
    localparam wr_state_t W_IDLE = 2'd0;
    localparam wr_state_t W_DATA = 2'd1;
    localparam wr_state_t W_RESP = 2'd2;

    typedef logic [0:0] rd_state_t;
    localparam rd_state_t R_IDLE = 1'b0;
    localparam rd_state_t R_DATA = 1'b1;

endpackage : axi_slave_ram_pkg
`default_nettype wire

// File: rtl/axi_slave_ram_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_slave_ram_if
// Description : AXI4 AW/W/B/AR/R bundle with master and slave modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_slave_ram_if #(
    parameter int AXI_WIDTH = 64,
    parameter int AXI_ID_W  = 4
);
    localparam int AXI_WSTRB_W = AXI_WIDTH >> 3;

    logic [AXI_ID_W-1:0]    awid;
    logic [29:0]            awaddr;
    logic [7:0]             awlen;
    logic [2:0]             awsize;
    logic [1:0]             awburst;
    logic                   awvalid;
    logic                   awready;

    logic [AXI_WIDTH-1:0]   wdata;
    logic [AXI_WSTRB_W-1:0] wstrb;
    logic                   wlast;
    logic                   wvalid;
    logic                   wready;

    logic [AXI_ID_W-1:0]    bid;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;

    logic [AXI_ID_W-1:0]    arid;
    logic [29:0]            araddr;
    logic [7:0]             arlen;
    logic [2:0]             arsize;
    logic [1:0]             arburst;
    logic                   arvalid;
    logic                   arready;

    logic [AXI_ID_W-1:0]    rid;
    logic [AXI_WIDTH-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rlast;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

endinterface : axi_slave_ram_if
`default_nettype wire

// File: rtl/axi_slave_ram_mem.sv
`default_nettype none
// ============================================================================
// Module      : axi_slave_ram_mem
// Description : Simple dual-port RAM, byte-enable write port, registered
//               read-first read port with combinational address.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_slave_ram_mem #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10,
    parameter int STRB_W = DATA_W >> 3
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic [STRB_W-1:0] i_wstrb,
    input  wire logic              i_re,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Sampling the array before the write's NBA lands gives read-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : axi_slave_ram_mem
`default_nettype wire

// File: rtl/axi_slave_ram.sv
`default_nettype none
// ============================================================================
// Module      : axi_slave_ram
// Description : AXI4 slave serving INCR bursts from on-chip byte-enable RAM.
//               Define AXI_SLV_BACKPRESSURE_EN to gate the readies with an LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_slave_ram
    import axi_slave_ram_pkg::*;
#(
    parameter int AXI_WIDTH   = 64,
    parameter int AXI_WSTRB_W = AXI_WIDTH >> 3,
    parameter int AXI_ID_W    = 4,
    parameter int MEM_AW      = 10
) (
    input  wire logic      clk,
    input  wire logic      rst,
    axi_slave_ram_if.slave s_axi
);

    localparam int LSB = $clog2(AXI_WSTRB_W);

    // ------------------------------------------------------------------
    // Ready gating
    // ------------------------------------------------------------------
    logic w_gate_aw;
    logic w_gate_w;
    logic w_gate_ar;

`ifdef AXI_SLV_BACKPRESSURE_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_gate_aw = r_lfsr[0];
    assign w_gate_w  = r_lfsr[5];
    assign w_gate_ar = r_lfsr[10];
`else
    assign w_gate_aw = 1'b1;
    assign w_gate_w  = 1'b1;
    assign w_gate_ar = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_t             r_wstate;
    wr_state_t             w_wstate_nxt;
    logic [AXI_ID_W-1:0]   r_w_id;
    logic [MEM_AW-1:0]     r_w_idx;
    logic [7:0]            r_w_cnt;
    logic [7:0]            r_w_len;
    logic                  r_w_err;

    logic                  w_awready_fsm;
    logic                  w_wready_fsm;
    logic                  w_bvalid;
    logic [AXI_ID_W-1:0]   w_bid;
    logic [1:0]            w_bresp;
    logic                  w_awready;
    logic                  w_wready;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_w_final;

    assign w_awready = w_awready_fsm & w_gate_aw;
    assign w_wready  = w_wready_fsm & w_gate_w;
    assign w_aw_hs   = s_axi.awvalid & w_awready;
    assign w_w_hs    = s_axi.wvalid & w_wready;
    assign w_w_final = (r_w_cnt == r_w_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_w_final) w_wstate_nxt = W_RESP;
            W_RESP:  if (s_axi.bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_awready_fsm = 1'b0;
        w_wready_fsm  = 1'b0;
        w_bvalid      = 1'b0;
        w_bid         = '0;
        w_bresp       = AXI_RESP_OKAY;
        case (r_wstate)
            W_IDLE:  w_awready_fsm = 1'b1;
            W_DATA:  w_wready_fsm  = 1'b1;
            W_RESP: begin
                w_bvalid = 1'b1;
                w_bid    = r_w_id;
                w_bresp  = r_w_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
            default: ;
        endcase
    end

    // The beat count ends the burst; a wlast disagreeing with it only flags SLVERR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_id  <= '0;
            r_w_idx <= '0;
            r_w_cnt <= '0;
            r_w_len <= '0;
            r_w_err <= 1'b0;
        end else if (w_aw_hs) begin
            r_w_id  <= s_axi.awid;
            r_w_idx <= s_axi.awaddr[LSB +: MEM_AW];
            r_w_cnt <= '0;
            r_w_len <= s_axi.awlen;
            r_w_err <= 1'b0;
        end else if (w_w_hs) begin
            r_w_idx <= r_w_idx + 1'b1;
            r_w_cnt <= r_w_cnt + 1'b1;
            if (s_axi.wlast != w_w_final) begin
                r_w_err <= 1'b1;
            end
        end
    end

    assign s_axi.awready = w_awready;
    assign s_axi.wready  = w_wready;
    assign s_axi.bvalid  = w_bvalid;
    assign s_axi.bid     = w_bid;
    assign s_axi.bresp   = w_bresp;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_t             r_rstate;
    rd_state_t             w_rstate_nxt;
    logic [AXI_ID_W-1:0]   r_r_id;
    logic [MEM_AW-1:0]     r_r_idx;
    logic [7:0]            r_r_cnt;
    logic [7:0]            r_r_len;

    logic                  w_arready_fsm;
    logic                  w_rvalid;
    logic                  w_rlast;
    logic [AXI_ID_W-1:0]   w_rid;
    logic                  w_arready;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_r_final;
    logic [MEM_AW-1:0]     w_ar_idx;
    logic                  w_mem_re;
    logic [MEM_AW-1:0]     w_mem_raddr;
    logic [AXI_WIDTH-1:0]  w_mem_rdata;

    assign w_arready = w_arready_fsm & w_gate_ar;
    assign w_ar_hs   = s_axi.arvalid & w_arready;
    assign w_r_hs    = w_rvalid & s_axi.rready;
    assign w_r_final = (r_r_cnt == r_r_len);
    assign w_ar_idx  = s_axi.araddr[LSB +: MEM_AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs && w_r_final) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_arready_fsm = 1'b0;
        w_rvalid      = 1'b0;
        w_rlast       = 1'b0;
        w_rid         = '0;
        case (r_rstate)
            R_IDLE:  w_arready_fsm = 1'b1;
            R_DATA: begin
                w_rvalid = 1'b1;
                w_rlast  = w_r_final;
                w_rid    = r_r_id;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_r_id  <= '0;
            r_r_idx <= '0;
            r_r_cnt <= '0;
            r_r_len <= '0;
        end else if (w_ar_hs) begin
            r_r_id  <= s_axi.arid;
            r_r_idx <= w_ar_idx;
            r_r_cnt <= '0;
            r_r_len <= s_axi.arlen;
        end else if (w_r_hs && !w_r_final) begin
            r_r_idx <= r_r_idx + 1'b1;
            r_r_cnt <= r_r_cnt + 1'b1;
        end
    end

    // The RAM output register doubles as rdata, so it only moves on AR or an accepted beat.
    assign w_mem_re    = w_ar_hs | (w_r_hs & ~w_r_final);
    assign w_mem_raddr = (r_rstate == R_IDLE) ? w_ar_idx : r_r_idx + 1'b1;

    axi_slave_ram_mem #(
        .DATA_W (AXI_WIDTH),
        .ADDR_W (MEM_AW),
        .STRB_W (AXI_WSTRB_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_w_hs & ~rst),
        .i_waddr (r_w_idx),
        .i_wdata (s_axi.wdata),
        .i_wstrb (s_axi.wstrb),
        .i_re    (w_mem_re),
        .i_raddr (w_mem_raddr),
        .o_rdata (w_mem_rdata)
    );

    assign s_axi.arready = w_arready;
    assign s_axi.rvalid  = w_rvalid;
    assign s_axi.rlast   = w_rlast;
    assign s_axi.rid     = w_rid;
    assign s_axi.rdata   = w_mem_rdata;
    assign s_axi.rresp   = AXI_RESP_OKAY;

    // Size, burst type and the aliased upper address bits carry no meaning here.
    logic w_unused_ok;
    assign w_unused_ok = ^{s_axi.awsize, s_axi.awburst, s_axi.arsize, s_axi.arburst,
                           s_axi.awaddr, s_axi.araddr};

endmodule : axi_slave_ram
`default_nettype wire

// File: tb/tb_axi_slave_ram.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_axi_slave_ram
// Description : Randomised self-checking bench for axi_slave_ram against a
//               word-array memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_slave_ram;

    localparam int DW    = 64;
    localparam int IDW   = 4;
    localparam int MAW   = 10;
    localparam int DEPTH = 1 << MAW;
    localparam int TMO   = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    axi_slave_ram_if #(.AXI_WIDTH(DW), .AXI_ID_W(IDW)) bus ();

    axi_slave_ram #(
        .AXI_WIDTH (DW),
        .AXI_ID_W  (IDW),
        .MEM_AW    (MAW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .s_axi (bus)
    );

    logic [63:0] ref_mem [DEPTH];
    logic [63:0] wq_data [$];
    logic [7:0]  wq_strb [$];
    logic [63:0] rd_data [$];
    logic        rd_last [$];
    logic [3:0]  rd_id   [$];

    function automatic void model_write(input int word, input logic [63:0] d, input logic [7:0] s);
        for (int b = 0; b < 8; b++)
            if (s[b]) ref_mem[word % DEPTH][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    function automatic void apply_model(input int word, input int len);
        for (int i = 0; i <= len; i++) model_write(word + i, wq_data[i], wq_strb[i]);
    endfunction

    function automatic logic [29:0] waddr(input int word);
        logic [29:0] a;
        a = 30'(word % DEPTH) << 3;
        a = a | (30'($urandom) & 30'h3FFF_E000);
        return a;
    endfunction

    // ---------------- channel drivers ----------------
    task automatic do_aw(input logic [3:0] id, input logic [29:0] addr, input int len);
        int n = 0;
        bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len);
        bus.awsize = 3'd3; bus.awburst = 2'b01; bus.awvalid = 1'b1;
        while (bus.awready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) begin total++; bad++; $display("FAIL aw_timeout: awready got 0 want 1"); end
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [29:0] addr, input int len);
        int n = 0;
        bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len);
        bus.arsize = 3'd3; bus.arburst = 2'b01; bus.arvalid = 1'b1;
        while (bus.arready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) begin total++; bad++; $display("FAIL ar_timeout: arready got 0 want 1"); end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
    endtask

    // Sends beats 0..len from the write queues; wlast is raised on beat wl_beat.
    task automatic do_w(input int len, input int wl_beat);
        int n;
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.wvalid = 1'b0; @(posedge clk); #1;
            end
            bus.wdata = wq_data[i]; bus.wstrb = wq_strb[i];
            bus.wlast = (i == wl_beat); bus.wvalid = 1'b1;
            n = 0;
            while (bus.wready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
            if (n >= TMO) begin
                total++; bad++; $display("FAIL w_timeout: wready got 0 want 1 beat %0d", i);
                break;
            end
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
    endtask

    task automatic do_b(output logic [3:0] id, output logic [1:0] resp);
        int n = 0;
        id = 4'hx; resp = 2'bxx;
        bus.bready = 1'b1;
        while (bus.bvalid !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) begin total++; bad++; $display("FAIL b_timeout: bvalid got 0 want 1"); end
        else begin id = bus.bid; resp = bus.bresp; end
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic do_r(input int len, input int stall_pct);
        int got = 0;
        int n = 0;
        rd_data.delete(); rd_last.delete(); rd_id.delete();
        while (got <= len && n < TMO) begin
            bus.rready = ($urandom_range(0, 99) >= stall_pct);
            if (bus.rvalid === 1'b1 && bus.rready) begin
                rd_data.push_back(bus.rdata); rd_last.push_back(bus.rlast); rd_id.push_back(bus.rid);
                got++;
            end
            @(posedge clk); #1; n++;
        end
        if (got <= len) begin total++; bad++; $display("FAIL r_timeout: beats got %0d want %0d", got, len + 1); end
        bus.rready = 1'b0;
    endtask

    task automatic fill_wq(input int len, input bit full_strb);
        wq_data.delete(); wq_strb.delete();
        for (int i = 0; i <= len; i++) begin
            wq_data.push_back({$urandom, $urandom});
            wq_strb.push_back((full_strb || $urandom_range(0, 2) != 0) ? 8'hFF : 8'($urandom));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.awready !== 1'b1) begin bad++; $display("FAIL rst_awready: got %b want 1", bus.awready); end
        total++; if (bus.arready !== 1'b1) begin bad++; $display("FAIL rst_arready: got %b want 1", bus.arready); end
        total++; if (bus.wready !== 1'b0) begin bad++; $display("FAIL rst_wready: got %b want 0", bus.wready); end
        total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL rst_bvalid: got %b want 0", bus.bvalid); end
        total++; if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b want 0", bus.rvalid); end
        total++; if (bus.rlast !== 1'b0) begin bad++; $display("FAIL rst_rlast: got %b want 0", bus.rlast); end
        total++; if (bus.rdata !== 64'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bus.rdata); end
        total++; if ({bus.bid, bus.bresp, bus.rid, bus.rresp} !== 12'h0) begin
            bad++; $display("FAIL rst_ids: got %h want 0", {bus.bid, bus.bresp, bus.rid, bus.rresp});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_burst();
        logic [3:0] bid; logic [1:0] br;
        wq_data.delete(); wq_strb.delete();
        for (int i = 0; i < 4; i++) begin wq_data.push_back(64'h11 * (i + 1)); wq_strb.push_back(8'hFF); end
        do_aw(4'hA, 30'h100, 3); do_w(3, 3); do_b(bid, br);
        apply_model(32, 3);
        total++; if (bid !== 4'hA) begin bad++; $display("FAIL basic_bid: got %h want a", bid); end
        total++; if (br !== 2'b00) begin bad++; $display("FAIL basic_bresp: got %b want 00", br); end
        do_ar(4'h5, 30'h100, 3); do_r(3, 0);
        for (int i = 0; i < rd_data.size(); i++) begin
            total++;
            if (rd_data[i] !== 64'h11 * (i + 1) || rd_last[i] !== (i == 3) || rd_id[i] !== 4'h5) begin
                bad++; $display("FAIL basic_beat%0d: got %h/%b/%h want %h/%b/5", i, rd_data[i], rd_last[i],
                                rd_id[i], 64'h11 * (i + 1), (i == 3));
            end
        end
        total++; if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL basic_rvalid_end: got %b want 0", bus.rvalid); end
    endtask

    task automatic test_strobe();
        logic [3:0] bid; logic [1:0] br;
        wq_data.delete(); wq_strb.delete();
        wq_data.push_back(64'hFFFF_FFFF_FFFF_FFFF); wq_strb.push_back(8'hFF);
        do_aw(4'h1, waddr(5), 0); do_w(0, 0); do_b(bid, br); apply_model(5, 0);
        wq_data[0] = 64'h0; wq_strb[0] = 8'h0F;
        do_aw(4'h2, waddr(5), 0); do_w(0, 0); do_b(bid, br); apply_model(5, 0);
        do_ar(4'h3, waddr(5), 0); do_r(0, 30);
        total++;
        if (rd_data.size() != 1 || rd_data[0] !== 64'hFFFF_FFFF_0000_0000 || rd_last[0] !== 1'b1) begin
            bad++; $display("FAIL strobe_read: got %h want ffffffff00000000", rd_data.size() ? rd_data[0] : 64'hx);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] bid; logic [1:0] br;
        fill_wq(3, 1'b1);
        do_aw(4'h7, waddr(DEPTH - 2), 3); do_w(3, 3); do_b(bid, br); apply_model(DEPTH - 2, 3);
        total++; if (br !== 2'b00) begin bad++; $display("FAIL wrap_bresp: got %b want 00", br); end
        do_ar(4'h8, waddr(0), 1); do_r(1, 0);
        for (int i = 0; i < rd_data.size(); i++) begin
            total++;
            if (rd_data[i] !== wq_data[2 + i]) begin
                bad++; $display("FAIL wrap_low%0d: got %h want %h", i, rd_data[i], wq_data[2 + i]);
            end
        end
        do_ar(4'h9, waddr(DEPTH - 2), 3); do_r(3, 25);
        for (int i = 0; i < rd_data.size(); i++) begin
            total++;
            if (rd_data[i] !== ref_mem[(DEPTH - 2 + i) % DEPTH] || rd_last[i] !== (i == 3)) begin
                bad++; $display("FAIL wrap_beat%0d: got %h/%b want %h/%b", i, rd_data[i], rd_last[i],
                                ref_mem[(DEPTH - 2 + i) % DEPTH], (i == 3));
            end
        end
    endtask

    task automatic test_wlast_err();
        logic [3:0] bid; logic [1:0] br;
        fill_wq(3, 1'b1);
        do_aw(4'hC, waddr(300), 3); do_w(3, 1); do_b(bid, br); apply_model(300, 3);
        total++; if (br !== 2'b10) begin bad++; $display("FAIL wlast_bresp: got %b want 10", br); end
        total++; if (bid !== 4'hC) begin bad++; $display("FAIL wlast_bid: got %h want c", bid); end
        do_ar(4'h2, waddr(300), 3); do_r(3, 0);
        for (int i = 0; i < rd_data.size(); i++) begin
            total++;
            if (rd_data[i] !== ref_mem[300 + i]) begin
                bad++; $display("FAIL wlast_beat%0d: got %h want %h", i, rd_data[i], ref_mem[300 + i]);
            end
        end
        fill_wq(1, 1'b1);
        do_aw(4'hD, waddr(310), 1); do_w(1, 1); do_b(bid, br); apply_model(310, 1);
        total++; if (br !== 2'b00) begin bad++; $display("FAIL wlast_clear: got %b want 00", br); end
    endtask

    task automatic test_rready_stall();
        logic [3:0] bid; logic [1:0] br;
        logic [63:0] old42, new42;
        int n;
        fill_wq(3, 1'b1);
        do_aw(4'h1, waddr(40), 3); do_w(3, 3); do_b(bid, br); apply_model(40, 3);
        old42 = ref_mem[42];
        new42 = {$urandom, $urandom};
        do_aw(4'h6, waddr(42), 0);
        do_ar(4'h4, waddr(40), 3);
        n = 0;
        while (bus.rvalid !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        bus.rready = 1'b1;
        total++; if (bus.rdata !== ref_mem[40] || bus.rlast !== 1'b0) begin
            bad++; $display("FAIL stall_beat0: got %h/%b want %h/0", bus.rdata, bus.rlast, ref_mem[40]);
        end
        @(posedge clk); #1;
        bus.rready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== ref_mem[41] || bus.rlast !== 1'b0 || bus.rid !== 4'h4) begin
                bad++; $display("FAIL stall_hold%0d: got %b/%h/%b want 1/%h/0", c, bus.rvalid, bus.rdata,
                                bus.rlast, ref_mem[41]);
            end
            @(posedge clk); #1;
        end
        n = 0;
        while (bus.wready !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        // Beat-1 acceptance captures word 42 on the same edge that writes it.
        bus.wdata = new42; bus.wstrb = 8'hFF; bus.wlast = 1'b1; bus.wvalid = 1'b1; bus.rready = 1'b1;
        total++; if (bus.rdata !== ref_mem[41]) begin
            bad++; $display("FAIL stall_beat1: got %h want %h", bus.rdata, ref_mem[41]);
        end
        @(posedge clk); #1;
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        total++; if (bus.rvalid !== 1'b1 || bus.rdata !== old42) begin
            bad++; $display("FAIL read_first: got %h want %h", bus.rdata, old42);
        end
        @(posedge clk); #1;
        total++; if (bus.rdata !== ref_mem[43] || bus.rlast !== 1'b1) begin
            bad++; $display("FAIL stall_beat3: got %h/%b want %h/1", bus.rdata, bus.rlast, ref_mem[43]);
        end
        @(posedge clk); #1;
        bus.rready = 1'b0;
        model_write(42, new42, 8'hFF);
        do_b(bid, br);
        total++; if (bid !== 4'h6 || br !== 2'b00) begin
            bad++; $display("FAIL stall_b: got %h/%b want 6/00", bid, br);
        end
        do_ar(4'h3, waddr(42), 0); do_r(0, 0);
        total++; if (rd_data.size() != 1 || rd_data[0] !== new42) begin
            bad++; $display("FAIL stall_new42: got %h want %h", rd_data.size() ? rd_data[0] : 64'hx, new42);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] bid; logic [1:0] br;
        fill_wq(3, 1'b1);
        do_aw(4'hE, waddr(100), 3); do_w(1, 99); apply_model(100, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.awready !== 1'b1 || bus.wready !== 1'b0 || bus.bvalid !== 1'b0) begin
            bad++; $display("FAIL midrst: got aw=%b w=%b b=%b want 1/0/0", bus.awready, bus.wready, bus.bvalid);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL midrst_nob: got %b want 0", bus.bvalid); end
        fill_wq(1, 1'b0);
        do_aw(4'hF, waddr(200), 1); do_w(1, 1); do_b(bid, br); apply_model(200, 1);
        total++; if (bid !== 4'hF || br !== 2'b00) begin
            bad++; $display("FAIL midrst_b: got %h/%b want f/00", bid, br);
        end
        do_ar(4'h1, waddr(200), 1); do_r(1, 20);
        for (int i = 0; i < rd_data.size(); i++) begin
            total++;
            if (rd_data[i] !== ref_mem[200 + i]) begin
                bad++; $display("FAIL midrst_rd%0d: got %h want %h", i, rd_data[i], ref_mem[200 + i]);
            end
        end
        do_ar(4'h1, waddr(100), 1); do_r(1, 0);
        for (int i = 0; i < rd_data.size(); i++) begin
            total++;
            if (rd_data[i] !== ref_mem[100 + i]) begin
                bad++; $display("FAIL midrst_part%0d: got %h want %h", i, rd_data[i], ref_mem[100 + i]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] bid, id; logic [1:0] br;
        int word, len;
        for (int it = 0; it < 12; it++) begin
            word = $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(0, 7);
            id   = 4'($urandom);
            fill_wq(len, 1'b0);
            do_aw(id, waddr(word), len); do_w(len, len); do_b(bid, br); apply_model(word, len);
            total++; if (bid !== id || br !== 2'b00) begin
                bad++; $display("FAIL rnd%0d_b: got %h/%b want %h/00", it, bid, br, id);
            end
            do_ar(~id, waddr(word), len); do_r(len, 35);
            for (int i = 0; i < rd_data.size(); i++) begin
                total++;
                if (rd_data[i] !== ref_mem[(word + i) % DEPTH] || rd_last[i] !== (i == len) || rd_id[i] !== ~id) begin
                    bad++; $display("FAIL rnd%0d_beat%0d: got %h/%b want %h/%b", it, i, rd_data[i], rd_last[i],
                                    ref_mem[(word + i) % DEPTH], (i == len));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] bid; logic [1:0] br;
        fill_wq(7, 1'b1);
        do_aw(4'h2, waddr(600), 7); do_w(7, 7); do_b(bid, br); apply_model(600, 7);
        fill_wq(7, 1'b0);
        fork
            begin do_aw(4'h3, waddr(700), 7); do_w(7, 7); do_b(bid, br); end
            begin do_ar(4'h4, waddr(600), 7); do_r(7, 20); end
        join
        apply_model(700, 7);
        total++; if (bid !== 4'h3 || br !== 2'b00) begin
            bad++; $display("FAIL b2b_b: got %h/%b want 3/00", bid, br);
        end
        for (int i = 0; i < rd_data.size(); i++) begin
            total++;
            if (rd_data[i] !== ref_mem[600 + i]) begin
                bad++; $display("FAIL b2b_rdA%0d: got %h want %h", i, rd_data[i], ref_mem[600 + i]);
            end
        end
        do_ar(4'h5, waddr(700), 7); do_r(7, 0);
        for (int i = 0; i < rd_data.size(); i++) begin
            total++;
            if (rd_data[i] !== ref_mem[700 + i] || rd_last[i] !== (i == 7)) begin
                bad++; $display("FAIL b2b_rdB%0d: got %h want %h", i, rd_data[i], ref_mem[700 + i]);
            end
        end
    endtask

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 64'hx;
        test_reset();
        test_basic_burst();
        test_strobe();
        test_wrap();
        test_wlast_err();
        test_rready_stall();
        test_reset_mid_burst();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_axi_slave_ram
`default_nettype wire
